// File: rtl/period_slew_limiter_pkg.sv
// Shared types and default sizing for the per-motor period slew limiter.
package slew_pkg;

   localparam int DEF_NUM_CH       = 24;
   localparam int DEF_PW           = 11;
   localparam int DEF_RESET_PERIOD = 1;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} slew_state_t;

   typedef logic [DEF_PW-1:0] period_t;

endpackage

// File: rtl/period_slew_limiter_step.sv
// One slew step: moves cur toward target by at most step, never overshooting.
module slew_step #(
   parameter int PW = 11
) (
   input  logic [PW-1:0] cur,
   input  logic [PW-1:0] target,
   input  logic [PW-1:0] step,
   output logic [PW-1:0] next_cur
);

   always_comb begin
      // NOTE: default assignment first so every path drives next_cur and no latch is inferred.
      next_cur = cur;
      if (cur < target)
         next_cur = (target - cur > step) ? cur + step : target;
      else if (cur > target)
         next_cur = (cur - target > step) ? cur - step : target;
   end

endmodule

// File: rtl/period_slew_limiter.sv
// Round-robin period slew limiter feeding the pwm channels.
// Optional emergency stop on a zero write: define PERIOD_SLEW_ESTOP_EN.
module period_slew_limiter
   import slew_pkg::*;
#(
   parameter int NUM_CH       = DEF_NUM_CH,
   parameter int PW           = DEF_PW,
   parameter int ADDR_W       = 5,
   parameter int TICK_DIV     = 50000,
   parameter int RESET_PERIOD = DEF_RESET_PERIOD
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [PW-1:0]        wr_data,
   input  logic [PW-1:0]        step,
   output logic [NUM_CH*PW-1:0] period_out,
   output logic                 busy,
   output logic                 tick
);

   localparam int                CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  PRESC_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_CH - 1);
   localparam logic [PW-1:0]     RST_VAL   = PW'(RESET_PERIOD);

   logic [CNT_W-1:0]  presc;
   slew_state_t       state;
   logic [ADDR_W-1:0] idx;
   logic              wr_seen;
   logic [PW-1:0]     target_q [NUM_CH];
   logic [PW-1:0]     cur_q    [NUM_CH];
   logic [PW-1:0]     nxt_cur;
   logic              all_match;
   logic              wr_ok;

   assign wr_ok = wr_en && (32'(wr_addr) < NUM_CH);

   slew_step #(.PW(PW)) u_step (
      .cur      (cur_q[idx]),
      .target   (target_q[idx]),
      .step     (step),
      .next_cur (nxt_cur)
   );

   always_comb begin
      all_match = 1'b1;
      for (int i = 0; i < NUM_CH; i++)
         if (cur_q[i] != target_q[i]) all_match = 1'b0;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign period_out[g*PW +: PW] = cur_q[g];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc   <= '0;
         tick    <= 1'b0;
         state   <= IDLE;
         idx     <= '0;
         busy    <= 1'b0;
         wr_seen <= 1'b0;
         // NOTE: the period arrays are reset because motors must start from a known period.
         for (int i = 0; i < NUM_CH; i++) begin
            target_q[i] <= RST_VAL;
            cur_q[i]    <= RST_VAL;
         end
      end else begin
         // NOTE: non-blocking throughout so every register samples pre-edge values.
         tick  <= (presc == PRESC_MAX);
         presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  state   <= SWEEP;
                  idx     <= '0;
                  wr_seen <= 1'b0;
               end
            end
            SWEEP: begin
               cur_q[idx] <= nxt_cur;
               if (idx == LAST_IDX) state <= DONE;
               else                 idx   <= idx + 1'b1;
            end
            DONE: begin
               if (all_match && !wr_seen) busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Writes come last so a write landing in DONE keeps busy set.
         if (wr_ok) begin
            target_q[wr_addr] <= wr_data;
            if (state == SWEEP) wr_seen <= 1'b1;
`ifdef PERIOD_SLEW_ESTOP_EN
            if (wr_data == '0)
               cur_q[wr_addr] <= '0;
            else if (wr_data != cur_q[wr_addr])
               busy <= 1'b1;
`else
            if (wr_data != cur_q[wr_addr]) busy <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: doc/period_slew_limiter.md
Name: period_slew_limiter

Overview:
- Sits between the SPI command decode/load logic and the per-motor pwm instances.
- Holds a target period per motor channel, written by the load logic.
- Drives each pwm period input with a current period that moves toward its target by at most `step` counts per tick, so motors never see step changes.
- Updates one channel per clock in a round-robin sweep after every prescaler tick.

Parameters:
- NUM_CH, 24, number of motor channels.
- PW, 11, period width in bits; matches the pwm period input.
- ADDR_W, 5, channel address width; must satisfy 2**ADDR_W >= NUM_CH.
- TICK_DIV, 50000, clocks per slew tick (1 ms at 50 MHz); must be >= NUM_CH+2.
- RESET_PERIOD, 1, reset value of every target and current period.

Ports:
- clk  input  1  system clock (CLK_50 at top level).
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  single-cycle strobe; writes wr_data as the target of wr_addr.
- wr_addr  input  ADDR_W  target channel.
- wr_data  input  PW  new target period.
- step  input  PW  maximum change per tick; sampled at each channel's update slot.
- period_out  output  NUM_CH*PW  current periods; channel i occupies [i*PW +: PW]; registered.
- busy  output  1  high while any channel's current period differs from its target.
- tick  output  1  one-cycle pulse at each sweep start (debug).

Behaviour:
- Reset (synchronous, active-high):
  - all targets and period_out channels = RESET_PERIOD.
  - prescaler = 0; FSM state = IDLE; sweep index = 0; busy = 0; tick = 0.
- Reset wins over everything in the same cycle. Reset mid-sweep abandons the sweep; no partial updates survive.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps.
  - tick pulses for one cycle on the wrap.
- FSM states:
  - IDLE: on tick, go to SWEEP with index = 0.
  - SWEEP: each cycle, update channel[index] and increment index. After index NUM_CH-1, go to DONE.
  - DONE: one cycle; evaluates busy; returns to IDLE.
- Latency:
  - channel i changes on the clock edge i+1 cycles after the tick pulse.
  - a full sweep takes NUM_CH+1 cycles.
  - a tick cannot occur during SWEEP or DONE, guaranteed by the TICK_DIV constraint.
- Update rule (d = |target - cur|, unsigned, no overflow):
  - if cur < target: cur <= (d > step) ? cur+step : target.
  - if cur > target: cur <= (d > step) ? cur-step : target.
  - if cur == target: cur unchanged.
  - step = 0 freezes all currents. cur never overshoots the target and never wraps.
- Writes:
  - accepted in any state except during reset; target updated on the next edge.
  - wr_addr >= NUM_CH: write ignored, no state change.
  - write to the channel being swept in the same cycle: the update uses the old target; the new target is stored and applied from the next tick.
  - back-to-back writes are allowed; the last write wins.
- busy:
  - set on the cycle after an accepted write whose wr_data != that channel's current period.
  - cleared in DONE only if every channel equals its target and no write was accepted during the sweep.
  - otherwise held.

Optional Feature:
- Macro: PERIOD_SLEW_ESTOP_EN.
- With the macro defined:
  - a write with wr_data == 0 sets that channel's target to 0 and its period_out to 0 on the next edge, bypassing the slew (emergency stop).
  - busy is not set by such a write.
- Without the macro: 0 is an ordinary target and is ramped like any other value.

Decomposition:
- Package slew_pkg:
  - default PW and NUM_CH localparams, and RESET_PERIOD.
  - FSM enum slew_state_t {IDLE, SWEEP, DONE}.
  - typedef period_t as logic [PW-1:0].
- Sub-module slew_step: purely combinational; inputs (cur, target, step); output next cur; implements the no-overshoot rule.
- The prescaler, FSM and storage arrays stay in the top module.

Test Plan (TICK_DIV=32 for simulation):
- Ramp up: step=100, write ch3 target 1001 -> ch3 reads 101, 201, ... 1001 after exactly 10 ticks; busy goes high the cycle after the write and low in DONE of tick 10.
- Non-multiple ramp down: ch3 at 1001, step=300, write 50 -> 701, 401, 101, 50 on successive ticks; never below 50.
- Invalid and frozen cases:
  - wr_addr=30 with wr_data=500 -> no channel, target or busy change.
  - step=0 with ch0 target 800 -> ch0 stays 1 for 5 ticks; busy remains 1.
- Collision: write ch5 target 900 in the cycle ch5 is swept (step=2047) -> ch5 unchanged this sweep; equals 900 after the next tick.
- Reset mid-sweep: assert reset at index 10 of a sweep -> next cycle all channels = 1, busy = 0, state IDLE; ticks resume after 32 cycles.
- ESTOP (macro defined): ch2 ramping at 600, write 0 -> period_out ch2 = 0 next edge. Without the macro: ch2 ramps down by step per tick.
